pc_gen: RTL and testbench



---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_btb.sv | 70 +++++++
 rtl/pc_gen.sv | 107 ++++++++++
 tb/tb_pc_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch PC generator.
// Build with PC_BTB_EN defined to add branch-target-buffer prediction.
package pc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        PENDING = 2'b01,
        HALTED  = 2'b10
    } pc_state_t;

    localparam int INST_BYTES = 4;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;
    localparam logic [1:0] CNT_ALLOC = CNT_WT;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Only instantiated when PC_BTB_EN is defined.
module pc_btb
    import pc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_hit,
    output logic            lookup_taken,
    output logic [XLEN-1:0] lookup_target,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid;
    logic [TAG_W-1:0]       tags    [BTB_ENTRIES];
    logic [XLEN-1:0]        targets [BTB_ENTRIES];
    logic [1:0]             cnts    [BTB_ENTRIES];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_match;
    logic [3:0]       unused_low_bits;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign u_idx = update_pc[IDX_W+1:2];
    assign u_tag = update_pc[XLEN-1:IDX_W+2];
    assign unused_low_bits = {lookup_pc[1:0], update_pc[1:0]};

    assign lookup_hit    = valid[l_idx] && (tags[l_idx] == l_tag);
    assign lookup_taken  = cnts[l_idx][1];
    assign lookup_target = targets[l_idx];

    assign u_match = valid[u_idx] && (tags[u_idx] == u_tag);

    // Train on resolved branches; new entries only for taken misses.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (update_valid) begin
            if (u_match) begin
                if (update_taken) begin
                    targets[u_idx] <= update_target;
                    if (cnts[u_idx] != CNT_ST)
                        cnts[u_idx] <= cnts[u_idx] + 2'd1;
                end else if (cnts[u_idx] != CNT_SNT) begin
                    cnts[u_idx] <= cnts[u_idx] - 2'd1;
                end
            end else if (update_taken) begin
                valid[u_idx]   <= 1'b1;
                tags[u_idx]    <= u_tag;
                targets[u_idx] <= update_target;
                cnts[u_idx]    <= CNT_ALLOC;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential/BTB advance, EX redirects, stall, halt.
// Optional BTB prediction is built when PC_BTB_EN is defined.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken,
    output logic [XLEN-1:0] current_pc,
    output logic            pc_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] next_pc_pred
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    pc_state_t       state;
    logic [XLEN-1:0] pending_pc;
    logic [XLEN-1:0] redir_aligned;
    logic [XLEN-1:0] seq_pc;

    assign redir_aligned = redirect_pc & ALIGN_MASK;
    assign seq_pc        = current_pc + XLEN'(INST_BYTES);

`ifdef PC_BTB_EN
    logic            btb_hit;
    logic            btb_taken;
    logic [XLEN-1:0] btb_target;

    pc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk           (clk),
        .reset         (reset),
        .lookup_pc     (current_pc),
        .lookup_hit    (btb_hit),
        .lookup_taken  (btb_taken),
        .lookup_target (btb_target),
        .update_valid  (update_valid && (state != HALTED)),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_taken  (update_taken)
    );

    assign pred_taken   = btb_hit & btb_taken;
    assign next_pc_pred = pred_taken ? btb_target : seq_pc;
`else
    logic unused_update;

    assign unused_update = ^{update_valid, update_pc,
                             update_target, update_taken};
    assign pred_taken    = 1'b0;
    assign next_pc_pred  = seq_pc;
`endif

    // Fetch FSM: halt > redirect > stall > advance; HALTED waits for reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            current_pc <= RESET_PC;
            pc_valid   <= 1'b1;
            pending_pc <= '0;
        end else if (state == HALTED) begin
            state <= HALTED;
        end else if (halt) begin
            state    <= HALTED;
            pc_valid <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (redirect_valid && !stall) begin
                        current_pc <= redir_aligned;
                    end else if (redirect_valid) begin
                        pending_pc <= redir_aligned;
                        state      <= PENDING;
                    end else if (!stall) begin
                        current_pc <= next_pc_pred;
                    end
                end
                PENDING: begin
                    if (stall) begin
                        if (redirect_valid)
                            pending_pc <= redir_aligned;
                    end else begin
                        current_pc <= redirect_valid ? redir_aligned
                                                     : pending_pc;
                        state      <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (RESET_PC = 0x100).
// BTB scenarios expect prediction only when PC_BTB_EN is defined.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic [31:0] current_pc;
    logic        pc_valid;
    logic        pred_taken;
    logic [31:0] next_pc_pred;

    int checks   = 0;
    int failures = 0;

    pc_gen #(
        .XLEN        (32),
        .RESET_PC    (32'h100),
        .BTB_ENTRIES (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_target  (update_target),
        .update_taken   (update_taken),
        .current_pc     (current_pc),
        .pc_valid       (pc_valid),
        .pred_taken     (pred_taken),
        .next_pc_pred   (next_pc_pred)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if (current_pc !== 32'h100 || pc_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_pc got=%h/%b exp=00000100/1",
                     current_pc, pc_valid);
        end
        checks++;
        if (pred_taken !== 1'b0 || next_pc_pred !== 32'h104) begin
            failures++;
            $display("FAIL reset_pred got=%b/%h exp=0/00000104",
                     pred_taken, next_pc_pred);
        end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (current_pc !== 32'h100 + 32'(4 * i) || pc_valid !== 1'b1) begin
                failures++;
                $display("FAIL free_run%0d got=%h/%b exp=%h/1", i,
                         current_pc, pc_valid, 32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall_redirect();
        go_to(32'h20);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            redirect_valid = (i == 1);
            redirect_pc    = 32'h400;
            tick();
            redirect_valid = 1'b0;
            checks++;
            if (current_pc !== 32'h20) begin
                failures++;
                $display("FAIL stall_hold%0d got=%h exp=00000020",
                         i, current_pc);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (current_pc !== 32'h400) begin
            failures++;
            $display("FAIL pending_apply got=%h exp=00000400", current_pc);
        end
        tick();
        checks++;
        if (current_pc !== 32'h404) begin
            failures++;
            $display("FAIL pending_after got=%h exp=00000404", current_pc);
        end
    endtask

    task automatic test_youngest_redirect();
        go_to(32'h60);
        stall = 1'b1;
        go_to(32'h40);
        go_to(32'h80);
        checks++;
        if (current_pc !== 32'h60) begin
            failures++;
            $display("FAIL multi_hold got=%h exp=00000060", current_pc);
        end
        stall = 1'b0;
        go_to(32'hC0);
        checks++;
        if (current_pc !== 32'hC0) begin
            failures++;
            $display("FAIL youngest got=%h exp=000000c0", current_pc);
        end
        tick();
        checks++;
        if (current_pc !== 32'hC4) begin
            failures++;
            $display("FAIL youngest_next got=%h exp=000000c4", current_pc);
        end
    endtask

    task automatic test_wrap_align();
        go_to(32'h203);
        checks++;
        if (current_pc !== 32'h200) begin
            failures++;
            $display("FAIL align got=%h exp=00000200", current_pc);
        end
        go_to(32'hFFFF_FFFC);
        checks++;
        if (next_pc_pred !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pred got=%h exp=00000000", next_pc_pred);
        end
        tick();
        checks++;
        if (current_pc !== 32'h0) begin
            failures++;
            $display("FAIL wrap got=%h exp=00000000", current_pc);
        end
    endtask

    task automatic test_halt();
        int bad = 0;
        go_to(32'h30);
        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        tick();
        halt           = 1'b0;
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            redirect_valid = i[0];
            stall          = i[1];
            tick();
            if (current_pc !== 32'h30 || pc_valid !== 1'b0)
                bad++;
        end
        redirect_valid = 1'b0;
        stall          = 1'b0;
        checks++;
        if (bad != 0 || current_pc !== 32'h30 || pc_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_park got=%h/%b bad=%0d exp=00000030/0",
                     current_pc, pc_valid, bad);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (current_pc !== 32'h100 || pc_valid !== 1'b1) begin
            failures++;
            $display("FAIL halt_reset got=%h/%b exp=00000100/1",
                     current_pc, pc_valid);
        end
        tick();
        checks++;
        if (current_pc !== 32'h104) begin
            failures++;
            $display("FAIL halt_resume got=%h exp=00000104", current_pc);
        end
    endtask

    task automatic test_reset_pending();
        stall = 1'b1;
        go_to(32'h600);
        stall = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (current_pc !== 32'h104) begin
            failures++;
            $display("FAIL reset_pending got=%h exp=00000104", current_pc);
        end
    endtask

    task automatic test_btb();
        logic [31:0] exp_next;
        logic        exp_taken;
`ifdef PC_BTB_EN
        exp_taken = 1'b1;
        exp_next  = 32'h80;
`else
        exp_taken = 1'b0;
        exp_next  = 32'h14;
`endif
        update_valid  = 1'b1;
        update_pc     = 32'h10;
        update_target = 32'h80;
        update_taken  = 1'b1;
        tick();
        update_valid = 1'b0;
        go_to(32'h10);
        checks++;
        if (pred_taken !== exp_taken || next_pc_pred !== exp_next) begin
            failures++;
            $display("FAIL btb_train got=%b/%h exp=%b/%h",
                     pred_taken, next_pc_pred, exp_taken, exp_next);
        end
        tick();
        checks++;
        if (current_pc !== exp_next) begin
            failures++;
            $display("FAIL btb_follow got=%h exp=%h", current_pc, exp_next);
        end
        update_valid = 1'b1;
        update_taken = 1'b0;
        tick();
        tick();
        update_valid = 1'b0;
        go_to(32'h10);
        checks++;
        if (pred_taken !== 1'b0 || next_pc_pred !== 32'h14) begin
            failures++;
            $display("FAIL btb_untrain got=%b/%h exp=0/00000014",
                     pred_taken, next_pc_pred);
        end
        tick();
        checks++;
        if (current_pc !== 32'h14) begin
            failures++;
            $display("FAIL btb_untrain_next got=%h exp=00000014",
                     current_pc);
        end
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        update_valid   = 1'b0;
        update_pc      = '0;
        update_target  = '0;
        update_taken   = 1'b0;
        #1;
        test_reset();
        test_stall_redirect();
        test_youngest_redirect();
        test_wrap_align();
        test_btb();
        test_halt();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
